// File: rtl/sync_dr_tx.sv
// Synchronous-to-dual-rail transmitter: encodes a binary word as a 4-phase
// dual-rail token and waits on synchronized C-element completion of all acks.
module sync_dr_tx #(
  parameter int WIDTH       = 4,
  parameter int NUM_ACK     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [WIDTH-1:0]   dr_t,
  output logic [WIDTH-1:0]   dr_f,
  input  logic [NUM_ACK-1:0] ack_in,
  output logic               busy,
  output logic [15:0]        tx_count,
  output logic               proto_err
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {WAIT_LOW, IDLE, DATA, SPACER} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dr_t_q, dr_t_d;
  logic [WIDTH-1:0]   dr_f_q, dr_f_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [NUM_ACK-1:0] sync_q [SYNC_STAGES];
  logic [NUM_ACK-1:0] ack_s;
  logic               all_hi, all_lo;

  // Sync flops reset high so a reset looks like a full pipeline until the
  // real (low) acks have propagated through the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= ack_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign all_hi = &ack_s;
  assign all_lo = ~|ack_s;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      dr_t_q  <= '0;
      dr_f_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dr_t_q  <= dr_t_d;
      dr_f_q  <= dr_f_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dr_t_d  = dr_t_q;
    dr_f_d  = dr_f_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      WAIT_LOW: begin
        dr_t_d = '0;
        dr_f_d = '0;
        if (all_lo) state_d = IDLE;
      end
      IDLE: begin
        if (!all_lo) err_d = 1'b1;
        if (in_valid) begin
          dr_t_d  = in_data;
          dr_f_d  = ~in_data;
          state_d = DATA;
        end
      end
      DATA: begin
        // Mixed acks leave the token on the rails indefinitely.
        if (all_hi) begin
          dr_t_d  = '0;
          dr_f_d  = '0;
          state_d = SPACER;
        end
      end
      SPACER: begin
        if (all_lo) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: begin
        dr_t_d  = '0;
        dr_f_d  = '0;
        state_d = WAIT_LOW;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == DATA) || (state_q == SPACER);
  assign dr_t      = dr_t_q;
  assign dr_f      = dr_f_q;
  assign tx_count  = cnt_q;
  assign proto_err = err_q;

endmodule
